// File: rtl/bank_ch_sched.sv
// Three-channel request scheduler: per-channel FIFOs, rotating-priority arbiter and
// a bank-port FSM that holds the bank idle for a recovery window after each issue.
module bank_ch_sched #(
  parameter int unsigned DATA_W        = 64,
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter int unsigned BANK_BUSY_CYC = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [2:0]            ch_req_valid_i,
  output logic [2:0]            ch_req_ready_o,
  input  logic [3*DATA_W-1:0]   ch_req_data_i,
  output logic                  bank_req_valid_o,
  input  logic                  bank_req_ready_i,
  output logic [DATA_W-1:0]     bank_req_data_o,
  output logic [1:0]            bank_req_id_o,
  output logic                  bank_busy_o
);

  localparam int unsigned NCH    = 3;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BUSY_W = $clog2(BANK_BUSY_CYC + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_BUSY} state_e;

  state_e              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [1:0]          id_q, id_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [BUSY_W-1:0]   bcnt_q, bcnt_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic [2:0]          rdy_q, rdy_d;

  logic [DATA_W-1:0]   mem_q [NCH][FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_q [NCH];
  logic [PTR_W-1:0]    wr_d [NCH];
  logic [PTR_W-1:0]    rd_q [NCH];
  logic [PTR_W-1:0]    rd_d [NCH];
  logic [CNT_W-1:0]    cnt_q [NCH];
  logic [CNT_W-1:0]    cnt_d [NCH];
  logic [DATA_W-1:0]   head [NCH];

  logic [2:0]          push, pop, nonempty;
  logic                hs;
  logic                win_found;
  logic [1:0]          win_id;
  logic [2:0]          scan;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign hs = valid_q & bank_req_ready_i;

  // FIFO control: ready comes from registered state, pops only on the granted channel
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      push[c]     = ch_req_valid_i[c] & rdy_q[c];
      pop[c]      = hs & (id_q == 2'(c));
      nonempty[c] = (cnt_q[c] != '0);
      head[c]     = mem_q[c][rd_q[c]];
      wr_d[c]     = push[c] ? ptr_inc(wr_q[c]) : wr_q[c];
      rd_d[c]     = pop[c] ? ptr_inc(rd_q[c]) : rd_q[c];
      cnt_d[c]    = cnt_q[c];
      if (push[c] && !pop[c]) cnt_d[c] = cnt_q[c] + CNT_W'(1);
      if (!push[c] && pop[c]) cnt_d[c] = cnt_q[c] - CNT_W'(1);
      rdy_d[c]    = (cnt_d[c] != CNT_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NCH; c++) begin
      if (push[c]) mem_q[c][wr_q[c]] <= ch_req_data_i[c*DATA_W +: DATA_W];
    end
  end

  // Round-robin scan starting at ptr_q, wrapping 2 -> 0
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan      = '0;
    for (int k = 0; k < NCH; k++) begin
      scan = 3'(ptr_q) + 3'(k);
      if (scan >= 3'd3) scan = scan - 3'd3;
      if (!win_found && nonempty[2'(scan)]) begin
        win_found = 1'b1;
        win_id    = 2'(scan);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    data_d  = data_q;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found && (bcnt_q == '0)) begin
          state_d = ST_ISSUE;
          id_d    = win_id;
          data_d  = head[win_id];
        end
      end
      ST_ISSUE: begin
        if (hs) begin
          ptr_d   = (id_q == 2'd2) ? 2'd0 : id_q + 2'd1;
          bcnt_d  = BUSY_W'(BANK_BUSY_CYC - 1);
          state_d = (BANK_BUSY_CYC == 1) ? ST_IDLE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bcnt_q <= BUSY_W'(1)) begin
          bcnt_d  = '0;
          state_d = ST_IDLE;
        end else begin
          bcnt_d  = bcnt_q - BUSY_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_ISSUE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
      bcnt_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 3'b111;
      for (int c = 0; c < NCH; c++) begin
        wr_q[c]  <= '0;
        rd_q[c]  <= '0;
        cnt_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      data_q  <= data_d;
      bcnt_q  <= bcnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      for (int c = 0; c < NCH; c++) begin
        wr_q[c]  <= wr_d[c];
        rd_q[c]  <= rd_d[c];
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  assign ch_req_ready_o   = rdy_q;
  assign bank_req_valid_o = valid_q;
  assign bank_req_data_o  = data_q;
  assign bank_req_id_o    = id_q;
  assign bank_busy_o      = busy_q;

endmodule

// File: tb/tb_bank_ch_sched.sv
// Directed bench for bank_ch_sched: inputs change and outputs are sampled on the falling edge.
module tb_bank_ch_sched;

  logic          clk;
  logic          rstn;
  logic [2:0]    vld;
  logic [2:0]    rdy;
  logic [191:0]  din;
  logic          bvalid;
  logic          bready;
  logic [63:0]   bdata;
  logic [1:0]    bid;
  logic          bbusy;

  int checks = 0;
  int errors = 0;

  bank_ch_sched #(.DATA_W(64), .FIFO_DEPTH(2), .BANK_BUSY_CYC(2)) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .ch_req_valid_i   (vld),
    .ch_req_ready_o   (rdy),
    .ch_req_data_i    (din),
    .bank_req_valid_o (bvalid),
    .bank_req_ready_i (bready),
    .bank_req_data_o  (bdata),
    .bank_req_id_o    (bid),
    .bank_busy_o      (bbusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setd(input int c, input logic [63:0] v);
    din[c*64 +: 64] = v;
  endtask

  task automatic chk_issue(input string tag, input logic [1:0] id, input logic [63:0] d);
    chk({tag, "_valid"}, 64'(bvalid), 64'd1);
    chk({tag, "_id"}, 64'(bid), 64'(id));
    chk({tag, "_data"}, bdata, d);
  endtask

  task automatic do_reset();
    rstn   = 1'b0;
    vld    = 3'b000;
    bready = 1'b0;
    nx();
    nx();
    chk("rst_valid", 64'(bvalid), 64'd0);
    chk("rst_id", 64'(bid), 64'd0);
    chk("rst_data", bdata, 64'd0);
    chk("rst_busy", 64'(bbusy), 64'd0);
    chk("rst_ready", 64'(rdy), 64'h7);
    rstn = 1'b1;
  endtask

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] q2[$];

  initial begin
    logic [63:0] v;
    logic [63:0] e;
    int exp_id;
    int last_hs;
    int hs_n;

    rstn = 1'b0; vld = '0; bready = 1'b0; din = '0;
    nx();
    do_reset();

    // single request on ch1
    setd(1, 64'hA5); vld = 3'b010; bready = 1'b1; nx();
    vld = 3'b000;
    chk("t1_arb_valid", 64'(bvalid), 64'd0);
    chk("t1_ready", 64'(rdy), 64'h7);
    nx();
    chk_issue("t1_issue", 2'd1, 64'hA5);
    chk("t1_busy", 64'(bbusy), 64'd1);
    chk("t1_ready2", 64'(rdy), 64'h7);
    nx();
    chk("t1_after_valid", 64'(bvalid), 64'd0);
    chk("t1_after_busy", 64'(bbusy), 64'd1);
    nx();
    chk("t1_idle_busy", 64'(bbusy), 64'd0);
    nx();
    chk("t1_one_beat", 64'(bvalid), 64'd0);

    // all channels push continuously
    do_reset();
    bready = 1'b1; vld = 3'b111;
    exp_id = 0; last_hs = -1; hs_n = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      for (int c = 0; c < 3; c++) begin
        v = 64'h1000 + 64'(c) * 64'd256 + 64'(cyc);
        setd(c, v);
        if (rdy[c]) begin
          if (c == 0) q0.push_back(v);
          else if (c == 1) q1.push_back(v);
          else q2.push_back(v);
        end
      end
      if (bvalid && bready) begin
        chk("t2_id", 64'(bid), 64'(exp_id));
        e = 64'hDEAD;
        if (bid == 2'd0 && q0.size() > 0) e = q0.pop_front();
        else if (bid == 2'd1 && q1.size() > 0) e = q1.pop_front();
        else if (bid == 2'd2 && q2.size() > 0) e = q2.pop_front();
        chk("t2_data", bdata, e);
        if (hs_n > 0) chk("t2_spacing", 64'(cyc - last_hs), 64'd3);
        last_hs = cyc;
        hs_n++;
        exp_id = (exp_id + 1) % 3;
      end
      nx();
    end
    chk("t2_hs_count", 64'(hs_n), 64'd10);
    vld = 3'b000;

    // grant held stable under backpressure
    do_reset();
    setd(0, 64'h100); vld = 3'b001; nx();
    vld = 3'b000;
    chk("t3_arb_valid", 64'(bvalid), 64'd0);
    nx();
    chk_issue("t3_hold0", 2'd0, 64'h100);
    setd(2, 64'h200); vld = 3'b100; nx();
    for (int i = 0; i < 5; i++) begin
      vld = 3'b000;
      chk_issue("t3_hold", 2'd0, 64'h100);
      if (i == 4) bready = 1'b1;
      nx();
    end
    chk("t3_busy_valid", 64'(bvalid), 64'd0);
    nx();
    chk("t3_idle_valid", 64'(bvalid), 64'd0);
    nx();
    chk_issue("t3_ch2", 2'd2, 64'h200);
    nx();
    chk("t3_done_valid", 64'(bvalid), 64'd0);
    nx();

    // ch2 FIFO fills while the bank stalls
    bready = 1'b0;
    setd(2, 64'h31); vld = 3'b100; nx();
    chk("t4_rdy_1", 64'(rdy), 64'h7);
    setd(2, 64'h32); nx();
    chk("t4_rdy_full", 64'(rdy), 64'h3);
    chk_issue("t4_first", 2'd2, 64'h31);
    setd(2, 64'h33); nx();
    chk("t4_rdy_held", 64'(rdy), 64'h3);
    chk_issue("t4_first_hold", 2'd2, 64'h31);
    bready = 1'b1; nx();
    chk("t4_rdy_after_pop", 64'(rdy), 64'h7);
    chk("t4_busy_valid", 64'(bvalid), 64'd0);
    nx();
    vld = 3'b000;
    chk("t4_rdy_third_in", 64'(rdy), 64'h3);
    nx();
    chk_issue("t4_second", 2'd2, 64'h32);
    nx();
    chk("t4_rdy_drain", 64'(rdy), 64'h7);
    nx();
    nx();
    chk_issue("t4_third", 2'd2, 64'h33);
    nx();
    nx();

    // pointer at 2 with ch0 and ch2 pending
    bready = 1'b0;
    setd(1, 64'h51); vld = 3'b010; nx();
    setd(0, 64'h50); setd(2, 64'h52); vld = 3'b101; nx();
    vld = 3'b000;
    chk_issue("t5_ch1", 2'd1, 64'h51);
    bready = 1'b1; nx();
    chk("t5_busy_valid", 64'(bvalid), 64'd0);
    nx();
    nx();
    chk_issue("t5_ch2", 2'd2, 64'h52);
    nx();
    nx();
    nx();
    chk_issue("t5_ch0_wrap", 2'd0, 64'h50);
    nx();
    nx();

    // asynchronous reset while issuing
    bready = 1'b0;
    setd(0, 64'h60); vld = 3'b001; nx();
    vld = 3'b000; nx();
    chk_issue("t6_pre", 2'd0, 64'h60);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(bvalid), 64'd0);
    chk("t6_rst_ready", 64'(rdy), 64'h7);
    chk("t6_rst_busy", 64'(bbusy), 64'd0);
    nx();
    rstn = 1'b1; bready = 1'b1;
    setd(1, 64'h71); setd(2, 64'h72); vld = 3'b110; nx();
    vld = 3'b000; nx();
    chk_issue("t6_ch1", 2'd1, 64'h71);
    nx();
    nx();
    nx();
    chk_issue("t6_ch2", 2'd2, 64'h72);
    for (int i = 0; i < 4; i++) begin
      nx();
      chk("t6_dropped", 64'(bvalid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
